midi_writer: RTL and testbench



---
 rtl/midi_pkg.sv | 35 +++
 rtl/uart_transmit.sv | 67 ++++++
 rtl/midi_writer.sv | 155 +++++++++++++++
 tb/tb_midi_writer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI definitions for the reader and writer paths: message types,
// message lengths and the standard bit rate.
package midi_pkg;

  localparam int MIDI_BAUD = 31250;

  typedef enum logic [2:0] {
    NOTE_OFF         = 3'd0,
    NOTE_ON          = 3'd1,
    POLY_PRESSURE    = 3'd2,
    CONTROL_CHANGE   = 3'd3,
    PROGRAM_CHANGE   = 3'd4,
    CHANNEL_PRESSURE = 3'd5,
    PITCH_BEND       = 3'd6,
    SYSTEM           = 3'd7
  } msg_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_STATUS,
    ST_SEND_DATA1,
    ST_SEND_DATA2,
    ST_DONE
  } writer_state_e;

  // Total bytes on the wire including status; 0 means the message is not sent.
  function automatic logic [1:0] msg_len(input msg_type_e t);
    case (t)
      PROGRAM_CHANGE, CHANNEL_PRESSURE: msg_len = 2'd2;
      SYSTEM:                           msg_len = 2'd0;
      default:                          msg_len = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/uart_transmit.sv
// 8N1 UART serialiser: a trigger while idle starts one frame; busy_out drops
// on the clock edge that ends the stop bit.
module uart_transmit #(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = midi_pkg::MIDI_BAUD
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] data_byte_in,
  input  logic       trigger_in,
  output logic       busy_out,
  output logic       tx_wire_out
);

  localparam int BAUD_DIVISOR = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int CW           = (BAUD_DIVISOR > 1) ? $clog2(BAUD_DIVISOR) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BAUD_DIVISOR - 1);

  logic          r_busy;
  logic          r_tx;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit_idx;
  logic [8:0]    r_shift;
  logic          w_bit_end;

  assign w_bit_end = (r_cnt == LAST_CNT);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_busy    <= 1'b0;
      r_tx      <= 1'b1;
      r_cnt     <= '0;
      r_bit_idx <= '0;
    end else if (!r_busy) begin
      if (trigger_in) begin
        r_busy    <= 1'b1;
        r_tx      <= 1'b0;
        r_cnt     <= '0;
        r_bit_idx <= '0;
      end
    end else if (w_bit_end) begin
      r_cnt <= '0;
      // Index 9 is the stop bit; the frame ends when its period expires.
      if (r_bit_idx == 4'd9) begin
        r_busy <= 1'b0;
      end else begin
        r_bit_idx <= r_bit_idx + 4'd1;
        r_tx      <= r_shift[0];
      end
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Data bits followed by the stop bit, shifted out LSB first.
  always_ff @(posedge clk_in) begin
    if (!r_busy && trigger_in) begin
      r_shift <= {1'b1, data_byte_in};
    end else if (r_busy && w_bit_end) begin
      r_shift <= {1'b1, r_shift[8:1]};
    end
  end

  assign busy_out    = r_busy;
  assign tx_wire_out = r_tx;

endmodule

// File: rtl/midi_writer.sv
// MIDI transmit path: frames one channel-voice message into status/data bytes,
// optionally suppressing repeated status bytes, and drives the UART serialiser.
module midi_writer
  import midi_pkg::*;
#(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = MIDI_BAUD,
  parameter int RUNNING_STATUS   = 1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [2:0] msg_type_in,
  input  logic [3:0] channel_in,
  input  logic [7:0] data_byte1_in,
  input  logic [7:0] data_byte2_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       busy_out,
  output logic       tx_wire_out
);

  writer_state_e r_state;
  logic          r_ready;
  logic          r_busy;
  logic          r_trigger;
  logic          r_launched;
  logic          r_rs_valid;
  logic [7:0]    r_rs_byte;
  logic [7:0]    r_status;
  logic [7:0]    r_data1;
  logic [7:0]    r_data2;
  logic          r_three_byte;
  logic [7:0]    r_tx_byte;

  msg_type_e     w_type;
  logic [7:0]    w_status;
  logic          w_accept;
  logic          w_skip_status;
  logic          w_uart_busy;
  logic          w_byte_done;
  logic          w_load_byte;
  logic [7:0]    w_load_val;

  assign w_type        = msg_type_e'(msg_type_in);
  assign w_status      = {1'b1, msg_type_in, channel_in};
  assign w_accept      = valid_in && r_ready;
  assign w_skip_status = (RUNNING_STATUS != 0) && r_rs_valid && (r_rs_byte == w_status);
  // A launched byte is finished once the trigger pulse has been seen and the serialiser is idle again.
  assign w_byte_done   = r_launched && !r_trigger && !w_uart_busy;

  // Chain the next byte on the byte-done cycle to keep the inter-byte gap short.
  always_comb begin
    w_load_byte = 1'b0;
    w_load_val  = r_data1;
    case (r_state)
      ST_SEND_STATUS: begin
        if (!r_launched) begin
          w_load_byte = 1'b1;
          w_load_val  = r_status;
        end else if (w_byte_done) begin
          w_load_byte = 1'b1;
          w_load_val  = r_data1;
        end
      end
      ST_SEND_DATA1: begin
        if (!r_launched) begin
          w_load_byte = 1'b1;
          w_load_val  = r_data1;
        end else if (w_byte_done && r_three_byte) begin
          w_load_byte = 1'b1;
          w_load_val  = r_data2;
        end
      end
      ST_SEND_DATA2: begin
        if (!r_launched) begin
          w_load_byte = 1'b1;
          w_load_val  = r_data2;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= ST_IDLE;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_trigger  <= 1'b0;
      r_launched <= 1'b0;
      r_rs_valid <= 1'b0;
    end else begin
      r_trigger <= w_load_byte;
      if (w_load_byte) begin
        r_launched <= 1'b1;
      end else if (w_byte_done) begin
        r_launched <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_type == SYSTEM) begin
              r_rs_valid <= 1'b0;
            end else begin
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
              if (w_skip_status) begin
                r_state <= ST_SEND_DATA1;
              end else begin
                r_state    <= ST_SEND_STATUS;
                r_rs_valid <= 1'b1;
              end
            end
          end
        end
        ST_SEND_STATUS: if (w_byte_done) r_state <= ST_SEND_DATA1;
        ST_SEND_DATA1:  if (w_byte_done) r_state <= r_three_byte ? ST_SEND_DATA2 : ST_DONE;
        ST_SEND_DATA2:  if (w_byte_done) r_state <= ST_DONE;
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (r_state == ST_IDLE && w_accept) begin
      r_status     <= w_status;
      r_data1      <= data_byte1_in & 8'h7F;
      r_data2      <= data_byte2_in & 8'h7F;
      r_three_byte <= (msg_len(w_type) == 2'd3);
      if (!w_skip_status) r_rs_byte <= w_status;
    end
    if (w_load_byte) r_tx_byte <= w_load_val;
  end

  uart_transmit #(
    .INPUT_CLOCK_FREQ(INPUT_CLOCK_FREQ),
    .BAUD_RATE       (BAUD_RATE)
  ) u_uart (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .data_byte_in(r_tx_byte),
    .trigger_in  (r_trigger),
    .busy_out    (w_uart_busy),
    .tx_wire_out (tx_wire_out)
  );

  assign ready_out = r_ready;
  assign busy_out  = r_busy;

endmodule

// File: tb/tb_midi_writer.sv
// Directed bench for midi_writer: two instances (running status on and off)
// with a 16-cycle bit period; the UART line is decoded at mid-bit.
module tb_midi_writer;

  localparam int DIV = 16;
  localparam int CLK_HZ = 31250 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] msg_type = '0;
  logic [3:0] channel = '0;
  logic [7:0] d1 = '0;
  logic [7:0] d2 = '0;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic       ready0, ready1, busy0, busy1, tx0, tx1;
  logic       sel = 1'b0;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  wire w_tx    = sel ? tx1 : tx0;
  wire w_ready = sel ? ready1 : ready0;
  wire w_busy  = sel ? busy1 : busy0;

  always #5 clk = ~clk;

  midi_writer #(.INPUT_CLOCK_FREQ(CLK_HZ), .BAUD_RATE(31250), .RUNNING_STATUS(1)) dut0 (
    .clk_in(clk), .rst_in(rst), .msg_type_in(msg_type), .channel_in(channel),
    .data_byte1_in(d1), .data_byte2_in(d2), .valid_in(v0),
    .ready_out(ready0), .busy_out(busy0), .tx_wire_out(tx0));

  midi_writer #(.INPUT_CLOCK_FREQ(CLK_HZ), .BAUD_RATE(31250), .RUNNING_STATUS(0)) dut1 (
    .clk_in(clk), .rst_in(rst), .msg_type_in(msg_type), .channel_in(channel),
    .data_byte1_in(d1), .data_byte2_in(d2), .valid_in(v1),
    .ready_out(ready1), .busy_out(busy1), .tx_wire_out(tx1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_msg(input logic [2:0] t, input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    msg_type = t; channel = c; d1 = a; d2 = b;
  endtask

  task automatic send(input logic [2:0] t, input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    while (!w_ready && n < 400) begin
      tick(1);
      n++;
    end
    check("ready_before_send", w_ready, 1);
    set_msg(t, c, a, b);
    if (sel) v1 = 1'b1; else v0 = 1'b1;
    tick(1);
    v0 = 1'b0; v1 = 1'b0;
  endtask

  task automatic wait_fall(output int polls);
    polls = 0;
    while (w_tx !== 1'b0 && polls < 300) begin
      tick(1);
      polls++;
    end
    if (polls >= 300) check("start_timeout", 0, 1);
  endtask

  task automatic read_bits(input string tag, output logic [7:0] b);
    tick(DIV / 2);
    check({tag, "_start"}, w_tx, 0);
    for (int i = 0; i < 8; i++) begin
      tick(DIV);
      b[i] = w_tx;
    end
    tick(DIV);
    check({tag, "_stop"}, w_tx, 1);
  endtask

  task automatic recv(input string tag, input logic [7:0] exp);
    int p;
    logic [7:0] b;
    wait_fall(p);
    read_bits(tag, b);
    check(tag, b, exp);
  endtask

  // Follow-on byte of a message: must start within 2 idle cycles after the stop bit.
  task automatic recv_next(input string tag, input logic [7:0] exp);
    int p;
    logic [7:0] b;
    wait_fall(p);
    check({tag, "_gap_ok"}, (p <= DIV / 2 + 2), 1);
    read_bits(tag, b);
    check(tag, b, exp);
  endtask

  // Called at mid-stop of the last byte: ready must rise within 2 cycles of stop end.
  task automatic msg_end(input string tag);
    tick(DIV / 2);
    for (int n = 0; n < 2 && !w_ready; n++) tick(1);
    check({tag, "_ready"}, w_ready, 1);
    check({tag, "_busy"}, w_busy, 0);
  endtask

  task automatic quiet(input string tag, input int n);
    logic all_high;
    all_high = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (w_tx !== 1'b1) all_high = 1'b0;
    end
    check(tag, all_high, 1);
  endtask

  initial begin
    int p;
    logic [7:0] b;

    tick(3);
    check("rst_ready", ready0, 1);
    check("rst_busy", busy0, 0);
    check("rst_tx", tx0, 1);
    check("rst_tx_rs0", tx1, 1);
    rst = 1'b0;
    tick(2);

    // Note-on ch0: exact two-edge latency, full three-byte frame.
    sel = 1'b0;
    send(3'd1, 4'd0, 8'h3C, 8'h64);
    check("accept_ready_low", w_ready, 0);
    check("accept_busy_high", w_busy, 1);
    wait_fall(p);
    check("start_latency", p, 2);
    read_bits("non_status", b);
    check("non_status", b, 8'h90);
    recv_next("non_d1", 8'h3C);
    recv_next("non_d2", 8'h64);
    msg_end("non");

    // Running status: the repeated 0x90 is suppressed.
    send(3'd1, 4'd0, 8'h3E, 8'h64);
    recv("rs_d1", 8'h3E);
    recv_next("rs_d2", 8'h64);
    msg_end("rs");

    // Same pair on the RUNNING_STATUS=0 instance: status every time.
    sel = 1'b1;
    send(3'd1, 4'd0, 8'h3C, 8'h64);
    recv("nors1_status", 8'h90);
    recv_next("nors1_d1", 8'h3C);
    recv_next("nors1_d2", 8'h64);
    msg_end("nors1");
    send(3'd1, 4'd0, 8'h3E, 8'h64);
    recv("nors2_status", 8'h90);
    recv_next("nors2_d1", 8'h3E);
    recv_next("nors2_d2", 8'h64);
    msg_end("nors2");
    sel = 1'b0;

    // Program change is two bytes; the following note-on needs its own status.
    send(3'd4, 4'd5, 8'h07, 8'h55);
    recv("pc_status", 8'hC5);
    recv_next("pc_d1", 8'h07);
    msg_end("pc");
    send(3'd1, 4'd5, 8'h3C, 8'h64);
    recv("non5_status", 8'h95);
    recv_next("non5_d1", 8'h3C);
    recv_next("non5_d2", 8'h64);
    msg_end("non5");

    // Data bit 7 is dropped.
    send(3'd3, 4'd2, 8'hBC, 8'hFF);
    recv("cc_status", 8'hB2);
    recv_next("cc_d1", 8'h3C);
    recv_next("cc_d2", 8'h7F);
    msg_end("cc");

    // valid held with changing inputs: only the first message goes out.
    set_msg(3'd1, 4'd2, 8'h10, 8'h20);
    v0 = 1'b1;
    tick(1);
    set_msg(3'd3, 4'd7, 8'h33, 8'h44);
    recv("hold_status", 8'h92);
    set_msg(3'd0, 4'd9, 8'h55, 8'h66);
    recv_next("hold_d1", 8'h10);
    recv_next("hold_d2", 8'h20);
    v0 = 1'b0;
    msg_end("hold");
    quiet("hold_no_second_msg", 60);

    // System message: nothing sent, ready stays available, status cache cleared.
    send(3'd7, 4'd2, 8'h10, 8'h20);
    check("sys_ready", w_ready, 1);
    check("sys_busy", w_busy, 0);
    quiet("sys_wire_idle", 60);
    send(3'd1, 4'd2, 8'h10, 8'h20);
    recv("post_sys_status", 8'h92);
    recv_next("post_sys_d1", 8'h10);
    recv_next("post_sys_d2", 8'h20);
    msg_end("post_sys");

    // Reset in the middle of bit 4 of the second byte.
    send(3'd1, 4'd3, 8'h40, 8'h50);
    recv("pre_rst_status", 8'h93);
    wait_fall(p);
    tick(DIV / 2 + 4 * DIV + DIV);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_tx", w_tx, 1);
    check("midrst_ready", w_ready, 1);
    check("midrst_busy", w_busy, 0);
    quiet("midrst_no_resume", 3 * DIV);
    send(3'd1, 4'd3, 8'h40, 8'h50);
    recv("post_rst_status", 8'h93);
    recv_next("post_rst_d1", 8'h40);
    recv_next("post_rst_d2", 8'h50);
    msg_end("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
